// File: rtl/rc4_decryptor.sv
// RC4 keystream generator and decrypt engine.
// Uses the permutation left in S RAM by the key-schedule shuffle. Each message
// byte advances i/j, swaps S[i] and S[j], fetches f = S[S[i]+S[j]], XORs f with
// the encrypted ROM byte and writes the result to decrypted RAM (8 cycles/byte).
// Optional build macro RC4_ASCII_CHECK_EN adds an o_invalid flag. The run stops
// early on the first decrypted byte that is not lowercase ASCII or space.
module rc4_decryptor #(
  parameter int unsigned RAM_WIDTH  = 8,
  parameter int unsigned RAM_LENGTH = 8,
  parameter int unsigned MSG_LENGTH = 32,
  parameter int unsigned MSG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic                  o_finished,
  input  logic [RAM_WIDTH-1:0]  i_s_ram_out,
  output logic                  o_s_write_enable,
  output logic [RAM_WIDTH-1:0]  o_s_ram_in,
  output logic [RAM_LENGTH-1:0] o_s_address,
  input  logic [RAM_WIDTH-1:0]  i_enc_rom_out,
  output logic [MSG_ADDR_W-1:0] o_enc_address,
  output logic                  o_dec_write_enable,
  output logic [RAM_WIDTH-1:0]  o_dec_ram_in,
  output logic [MSG_ADDR_W-1:0] o_dec_address
`ifdef RC4_ASCII_CHECK_EN
  ,
  output logic                  o_invalid
`endif
);

  typedef enum logic [3:0] {
    ST_AWAIT_START,
    ST_REQ_SI,
    ST_CAP_SI,
    ST_CAP_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_REQ_F,
    ST_CAP_F,
    ST_WR_DEC,
    ST_FINISHED
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [RAM_LENGTH-1:0] r_i;
  logic [RAM_LENGTH-1:0] r_j;
  logic [MSG_ADDR_W-1:0] r_k;
  logic [RAM_WIDTH-1:0]  r_si;
  logic [RAM_WIDTH-1:0]  r_sj;
  logic [RAM_WIDTH-1:0]  r_f;
  logic [RAM_WIDTH-1:0]  r_enc;
  logic                  r_start_d;

  logic                  w_start_edge;
  logic [RAM_LENGTH-1:0] w_i_inc;
  logic [RAM_LENGTH-1:0] w_next_j;
  logic [RAM_LENGTH-1:0] w_f_addr;
  logic [RAM_WIDTH-1:0]  w_dec_byte;
  logic                  w_last;
  logic                  w_stop;

  assign w_start_edge = i_start & ~r_start_d;
  assign w_i_inc      = r_i + RAM_LENGTH'(1);
  assign w_next_j     = r_j + RAM_LENGTH'(i_s_ram_out);
  assign w_f_addr     = RAM_LENGTH'(r_si) + RAM_LENGTH'(r_sj);
  assign w_dec_byte   = r_f ^ r_enc;
  assign w_last       = (r_k == MSG_ADDR_W'(MSG_LENGTH - 1));

`ifdef RC4_ASCII_CHECK_EN
  logic r_invalid;
  logic w_ascii_ok;

  // Accept only 'a'..'z' and space as plausible plaintext
  assign w_ascii_ok = ((w_dec_byte >= RAM_WIDTH'(8'h61)) && (w_dec_byte <= RAM_WIDTH'(8'h7A)))
                    || (w_dec_byte == RAM_WIDTH'(8'h20));
  assign w_stop     = w_last | ~w_ascii_ok;
  assign o_invalid  = r_invalid;

  // Invalid flag: set on a rejected byte, cleared by the next launch
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_invalid <= 1'b0;
    end else if (r_state == ST_AWAIT_START && w_start_edge) begin
      r_invalid <= 1'b0;
    end else if (r_state == ST_WR_DEC && !w_ascii_ok) begin
      r_invalid <= 1'b1;
    end
  end
`else
  assign w_stop = w_last;
`endif

  // Message index addresses both the encrypted ROM and the decrypted RAM
  assign o_enc_address = r_k;
  assign o_dec_address = r_k;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_AWAIT_START;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and memory strobes/addresses decoded from the current state
  always_comb begin
    w_state_nxt        = r_state;
    o_s_address        = '0;
    o_s_ram_in         = '0;
    o_s_write_enable   = 1'b0;
    o_dec_write_enable = 1'b0;
    o_dec_ram_in       = '0;
    o_finished         = 1'b0;
    case (r_state)
      ST_AWAIT_START: begin
        if (w_start_edge) begin
          w_state_nxt = ST_REQ_SI;
        end
      end
      ST_REQ_SI: begin
        o_s_address = w_i_inc;
        w_state_nxt = ST_CAP_SI;
      end
      ST_CAP_SI: begin
        o_s_address = w_next_j;
        w_state_nxt = ST_CAP_SJ;
      end
      ST_CAP_SJ: begin
        w_state_nxt = ST_WR_SI;
      end
      ST_WR_SI: begin
        o_s_address      = r_i;
        o_s_ram_in       = r_sj;
        o_s_write_enable = 1'b1;
        w_state_nxt      = ST_WR_SJ;
      end
      ST_WR_SJ: begin
        o_s_address      = r_j;
        o_s_ram_in       = r_si;
        o_s_write_enable = 1'b1;
        w_state_nxt      = ST_REQ_F;
      end
      ST_REQ_F: begin
        o_s_address = w_f_addr;
        w_state_nxt = ST_CAP_F;
      end
      ST_CAP_F: begin
        w_state_nxt = ST_WR_DEC;
      end
      ST_WR_DEC: begin
        o_dec_ram_in       = w_dec_byte;
        o_dec_write_enable = 1'b1;
        w_state_nxt        = w_stop ? ST_FINISHED : ST_REQ_SI;
      end
      ST_FINISHED: begin
        o_finished  = 1'b1;
        w_state_nxt = ST_AWAIT_START;
      end
      default: begin
        w_state_nxt = ST_AWAIT_START;
      end
    endcase
  end

  // Datapath registers: indices, swap operands, keystream and ROM byte
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_si      <= '0;
      r_sj      <= '0;
      r_f       <= '0;
      r_enc     <= '0;
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= i_start;
      case (r_state)
        ST_AWAIT_START: begin
          if (w_start_edge) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
          end
        end
        ST_REQ_SI: r_i <= w_i_inc;
        ST_CAP_SI: begin
          r_si <= i_s_ram_out;
          r_j  <= w_next_j;
        end
        ST_CAP_SJ: r_sj <= i_s_ram_out;
        ST_CAP_F: begin
          r_f   <= i_s_ram_out;
          r_enc <= i_enc_rom_out;
        end
        ST_WR_DEC: begin
          if (!w_stop) begin
            r_k <= r_k + MSG_ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decryptor.sv
// Bench for rc4_decryptor: synchronous memory models around the DUT, a
// software RC4 PRGA reference, known-answer table plus multi-cycle sequences.
module tb_rc4_decryptor;

  localparam int unsigned MSG_LEN = 9;
  localparam int unsigned AW      = 5;
  localparam int          RUN_CYC = MSG_LEN * 8 + 1;
  localparam logic [7:0]  MARK    = 8'hAA;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           fin;
  logic           s_we;
  logic [7:0]     s_din;
  logic [7:0]     s_addr;
  logic [7:0]     s_rdata;
  logic [7:0]     enc_rdata;
  logic [AW-1:0]  enc_addr;
  logic           dec_we;
  logic [7:0]     dec_din;
  logic [AW-1:0]  dec_addr;
`ifdef RC4_ASCII_CHECK_EN
  logic           invalid;
`endif

  always #5 clk = ~clk;

  rc4_decryptor #(
    .RAM_WIDTH (8),
    .RAM_LENGTH(8),
    .MSG_LENGTH(MSG_LEN),
    .MSG_ADDR_W(AW)
  ) u_dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_start           (start),
    .o_finished        (fin),
    .i_s_ram_out       (s_rdata),
    .o_s_write_enable  (s_we),
    .o_s_ram_in        (s_din),
    .o_s_address       (s_addr),
    .i_enc_rom_out     (enc_rdata),
    .o_enc_address     (enc_addr),
    .o_dec_write_enable(dec_we),
    .o_dec_ram_in      (dec_din),
    .o_dec_address     (dec_addr)
`ifdef RC4_ASCII_CHECK_EN
    ,
    .o_invalid         (invalid)
`endif
  );

  // Memories
  logic [7:0] s_mem   [256];
  logic [7:0] s_init  [256];
  logic [7:0] enc_mem [32];
  logic [7:0] dec_mem [32];
  logic       s_load;
  logic       dec_clr;
  int         dec_wr_cnt = 0;
  int         fin_cnt    = 0;

  always @(posedge clk) begin
    if (s_load) begin
      for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
    end else if (s_we) begin
      s_mem[s_addr] <= s_din;
    end
    s_rdata   <= s_mem[s_addr];
    enc_rdata <= enc_mem[enc_addr];
    if (dec_clr) begin
      for (int x = 0; x < 32; x++) dec_mem[x] <= MARK;
    end else if (dec_we) begin
      dec_mem[dec_addr] <= dec_din;
    end
  end

  always @(negedge clk) begin
    if (dec_we) dec_wr_cnt <= dec_wr_cnt + 1;
    if (fin)    fin_cnt    <= fin_cnt + 1;
  end

  // Reference model
  logic [7:0] m_s   [256];
  logic [7:0] m_dec [32];

  task automatic model_run(input int nbytes);
    int i;
    int j;
    int a;
    int b;
    logic [7:0] t;
    i = 0;
    j = 0;
    for (int n = 0; n < nbytes; n++) begin
      i = (i + 1) % 256;
      a = m_s[i];
      j = (j + a) % 256;
      t = m_s[i];
      m_s[i] = m_s[j];
      m_s[j] = t;
      a = m_s[i];
      b = m_s[j];
      m_dec[n] = m_s[(a + b) % 256] ^ enc_mem[n];
    end
  endtask

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic build_identity();
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
  endtask

  task automatic build_key_s();
    logic [23:0] kp;
    logic [7:0]  t;
    int          j;
    int          a;
    int          kb;
    kp = 24'h4B6579;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      a  = s_init[i];
      kb = kp[23 - 8 * (i % 3) -: 8];
      j  = (j + a + kb) % 256;
      t = s_init[i];
      s_init[i] = s_init[j];
      s_init[j] = t;
    end
  endtask

  task automatic build_random_s();
    int r;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      t = s_init[x];
      s_init[x] = s_init[r];
      s_init[r] = t;
    end
  endtask

  task automatic load_s();
    for (int x = 0; x < 256; x++) m_s[x] = s_init[x];
    @(negedge clk) s_load = 1'b1;
    @(negedge clk) s_load = 1'b0;
  endtask

  task automatic clr_dec();
    @(negedge clk) dec_clr = 1'b1;
    @(negedge clk) dec_clr = 1'b0;
  endtask

  task automatic fill_enc(input logic [7:0] fill, input bit use_ct);
    logic [71:0] ct;
    ct = 72'hBBF316E8D940AF0AD3;
    for (int b = 0; b < 32; b++) enc_mem[b] = (use_ct && b < 9) ? ct[71 - 8 * b -: 8] : fill;
  endtask

  task automatic wait_fin(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!fin && cyc < 2000);
  endtask

  task automatic launch(output int cyc);
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    wait_fin(cyc);
  endtask

  // Full run: finish latency, pulse width, write and pulse counts
  task automatic run_std(input string tag);
    int cyc;
    int w0;
    int f0;
    w0 = dec_wr_cnt;
    f0 = fin_cnt;
    launch(cyc);
    chk({tag, "_fin_cycle"}, cyc, RUN_CYC);
    @(negedge clk);
    chk({tag, "_fin_width"}, fin, 0);
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_dec_writes"}, dec_wr_cnt - w0, MSG_LEN);
    chk({tag, "_fin_pulses"}, fin_cnt - f0, 1);
  endtask

  task automatic chk_dec_model(input string tag, input int n);
    for (int b = 0; b < n; b++) chk($sformatf("%s_dec%0d", tag, b), dec_mem[b], m_dec[b]);
  endtask

  task automatic chk_s_model(input string tag);
    int nbad;
    nbad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) nbad++;
    chk({tag, "_s_final"}, nbad, 0);
  endtask

  task automatic chk_untouched(input string tag, input int from);
    int nbad;
    nbad = 0;
    for (int b = from; b < int'(MSG_LEN); b++) if (dec_mem[b] !== MARK) nbad++;
    chk({tag, "_untouched"}, nbad, 0);
  endtask

  typedef struct {
    int          s_mode;
    logic [7:0]  enc_fill;
    bit          use_ct;
    int          nchk;
    logic [71:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          cyc;
    int          w0;
    int          f0;
    int          nwe;
    int          quiet;
    logic [71:0] e;

    rst     = 1'b1;
    start   = 1'b0;
    s_load  = 1'b0;
    dec_clr = 1'b0;
    for (int b = 0; b < 32; b++) enc_mem[b] = 8'h00;

    // mode 0 = identity S, mode 1 = KSA("Key")
    vecs[0] = '{0, 8'h00, 1'b0, 2, 72'h020500000000000000};
    vecs[1] = '{1, 8'h00, 1'b1, 9, 72'h506C61696E74657874};
    vecs[2] = '{1, 8'h00, 1'b0, 9, 72'hEB9F7781B734CA72A7};
    vecs[3] = '{1, 8'hFF, 1'b0, 9, 72'h1460887E48CB358D58};
    vecs[4] = '{0, 8'hFF, 1'b0, 2, 72'hFDFA00000000000000};

    repeat (3) @(negedge clk);
    chk("rst_finished", fin, 0);
    chk("rst_s_we", s_we, 0);
    chk("rst_dec_we", dec_we, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_din", s_din, 0);
    chk("rst_enc_addr", enc_addr, 0);
    chk("rst_dec_addr", dec_addr, 0);
    chk("rst_dec_din", dec_din, 0);
    rst = 1'b0;
    @(negedge clk);

`ifdef RC4_ASCII_CHECK_EN
    chk("rst_invalid", invalid, 0);
    build_key_s();
    load_s();
    fill_enc(8'h00, 1'b0);
    clr_dec();
    model_run(1);
    w0 = dec_wr_cnt;
    launch(cyc);
    chk("ascii_fin_cycle", cyc, 9);
    chk("ascii_invalid", invalid, 1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ascii_dec_writes", dec_wr_cnt - w0, 1);
    chk("ascii_dec0_const", dec_mem[0], 8'hEB);
    chk_dec_model("ascii", 1);
    chk_untouched("ascii", 1);
    chk_s_model("ascii");
    repeat (5) @(negedge clk);
    chk("ascii_invalid_hold", invalid, 1);
    rst = 1'b1;
    #1;
    chk("ascii_invalid_rst", invalid, 0);
    @(negedge clk) rst = 1'b0;
`else
    // Known-answer table
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].s_mode == 0) build_identity();
      else build_key_s();
      load_s();
      fill_enc(vecs[v].enc_fill, vecs[v].use_ct);
      clr_dec();
      model_run(MSG_LEN);
      run_std($sformatf("vec%0d", v));
      e = vecs[v].exp;
      for (int b = 0; b < vecs[v].nchk; b++)
        chk($sformatf("vec%0d_kat%0d", v, b), dec_mem[b], e[71 - 8 * b -: 8]);
      chk_dec_model($sformatf("vec%0d", v), MSG_LEN);
      chk_s_model($sformatf("vec%0d", v));
    end

    // Start held high: one run only, then a fresh edge reruns on mutated S
    build_key_s();
    load_s();
    fill_enc(8'h00, 1'b1);
    clr_dec();
    model_run(MSG_LEN);
    w0 = dec_wr_cnt;
    f0 = fin_cnt;
    launch(cyc);
    chk("held_fin_cycle", cyc, RUN_CYC);
    repeat (30) @(negedge clk);
    chk("held_dec_writes", dec_wr_cnt - w0, MSG_LEN);
    chk("held_fin_pulses", fin_cnt - f0, 1);
    chk_dec_model("held", MSG_LEN);
    clr_dec();
    model_run(MSG_LEN);
    run_std("held2");
    chk_dec_model("held2", MSG_LEN);
    chk_s_model("held2");

    // Reset during WR_SI of byte 3 (7th S write strobe)
    build_key_s();
    load_s();
    fill_enc(8'h00, 1'b1);
    clr_dec();
    model_run(3);
    w0 = dec_wr_cnt;
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    nwe = 0;
    cyc = 0;
    while (nwe < 7 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (s_we) nwe++;
    end
    chk("abort_reached", nwe, 7);
    rst   = 1'b1;
    start = 1'b0;
    #1;
    chk("abort_s_we_async", s_we, 0);
    chk("abort_dec_we", dec_we, 0);
    @(negedge clk) rst = 1'b0;
    quiet = 0;
    repeat (12) begin
      @(negedge clk);
      if (s_we || dec_we || fin) quiet++;
    end
    chk("abort_idle", quiet, 0);
    chk("abort_dec_writes", dec_wr_cnt - w0, 3);
    chk_dec_model("abort", 3);
    chk_untouched("abort", 3);
    chk_s_model("abort");
    model_run(MSG_LEN);
    run_std("rerun");
    chk_dec_model("rerun", MSG_LEN);
    chk_s_model("rerun");

    // Start toggling while busy must not disturb the run
    build_random_s();
    load_s();
    for (int b = 0; b < 32; b++) enc_mem[b] = 8'($urandom);
    clr_dec();
    model_run(MSG_LEN);
    w0 = dec_wr_cnt;
    f0 = fin_cnt;
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!fin) start = (cyc < 50) ? 1'($urandom_range(1, 0)) : 1'b0;
    end while (!fin && cyc < 2000);
    chk("glitch_fin_cycle", cyc, RUN_CYC);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_dec_writes", dec_wr_cnt - w0, MSG_LEN);
    chk("glitch_fin_pulses", fin_cnt - f0, 1);
    chk_dec_model("glitch", MSG_LEN);
    chk_s_model("glitch");

    // Random permutations and ciphertext, two back-to-back runs each
    for (int r = 0; r < 3; r++) begin
      build_random_s();
      load_s();
      for (int b = 0; b < 32; b++) enc_mem[b] = 8'($urandom);
      clr_dec();
      model_run(MSG_LEN);
      run_std($sformatf("rnd%0da", r));
      chk_dec_model($sformatf("rnd%0da", r), MSG_LEN);
      chk_s_model($sformatf("rnd%0da", r));
      for (int b = 0; b < 32; b++) enc_mem[b] = 8'($urandom);
      model_run(MSG_LEN);
      run_std($sformatf("rnd%0db", r));
      chk_dec_model($sformatf("rnd%0db", r), MSG_LEN);
      chk_s_model($sformatf("rnd%0db", r));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
